// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter: request payload and requester ID.
package mem_port_arbiter_pkg;

    typedef struct packed {
        logic [31:0] a;
        logic        we;
        logic [3:0]  be;
        logic [31:0] d;
    } mem_req_t;

    typedef enum logic {
        SRC_IF = 1'b0,
        SRC_LS = 1'b1
    } src_t;

endpackage

// File: rtl/mem_port_arbiter_src_fifo.sv
// In-order FIFO of requester IDs; any depth >= 1, pointers wrap modulo depth.
module mem_port_arbiter_src_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter type T = logic
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  T     push_data,
    input  logic pop,
    output logic full,
    output logic empty,
    output T     head
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    T              mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          push_ok, pop_ok;

    assign full    = (count_q == CW'(DEPTH));
    assign empty   = (count_q == '0);
    assign head    = mem_q[rd_ptr_q];
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + PW'(1);
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + PW'(1);
        end
        if (push_ok && !pop_ok) begin
            count_d = count_q + CW'(1);
        end else if (pop_ok && !push_ok) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: entries are only read while the count says they are valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between fetch and load/store,
// with grant lock during memory stalls and in-order response routing.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req_valid,
    output logic        if_req_ready,
    input  mem_req_t    if_req_data,
    output logic        if_resp_valid,
    input  logic        if_resp_ready,
    output logic [31:0] if_resp_data,
    input  logic        ls_req_valid,
    output logic        ls_req_ready,
    input  mem_req_t    ls_req_data,
    output logic        ls_resp_valid,
    input  logic        ls_resp_ready,
    output logic [31:0] ls_resp_data,
    output logic        mem_req_valid,
    input  logic        mem_req_ready,
    output mem_req_t    mem_req_data,
    input  logic        mem_resp_valid,
    output logic        mem_resp_ready,
    input  logic [31:0] mem_resp_data
);
    src_t last_q, last_d;
    logic locked_q, locked_d;
    src_t lock_src_q, lock_src_d;

    src_t sel;
    logic sel_valid;
    logic lock_hold;
    logic req_fire;
    logic resp_fire;
    logic fifo_full, fifo_empty;
    src_t fifo_head;

    always_comb begin
        lock_hold = locked_q && ((lock_src_q == SRC_IF) ? if_req_valid : ls_req_valid);
        if (lock_hold) begin
            sel = lock_src_q;
        end else if (if_req_valid && !ls_req_valid) begin
            sel = SRC_IF;
        end else if (ls_req_valid && !if_req_valid) begin
            sel = SRC_LS;
        end else if (last_q == SRC_IF) begin
            sel = SRC_LS;
        end else begin
            sel = SRC_IF;
        end
        sel_valid = (sel == SRC_IF) ? if_req_valid : ls_req_valid;
    end

    // Full blocks the request side regardless of a same-cycle pop, keeping resp->req paths apart.
    assign mem_req_valid = sel_valid && !fifo_full;
    assign mem_req_data  = (sel == SRC_IF) ? if_req_data : ls_req_data;
    assign if_req_ready  = (sel == SRC_IF) && mem_req_ready && !fifo_full;
    assign ls_req_ready  = (sel == SRC_LS) && mem_req_ready && !fifo_full;
    assign req_fire      = mem_req_valid && mem_req_ready;

    assign if_resp_valid  = mem_resp_valid && !fifo_empty && (fifo_head == SRC_IF);
    assign ls_resp_valid  = mem_resp_valid && !fifo_empty && (fifo_head == SRC_LS);
    assign if_resp_data   = mem_resp_data;
    assign ls_resp_data   = mem_resp_data;
    assign mem_resp_ready = !fifo_empty && ((fifo_head == SRC_IF) ? if_resp_ready : ls_resp_ready);
    assign resp_fire      = mem_resp_valid && mem_resp_ready;

    always_comb begin
        last_d     = last_q;
        locked_d   = lock_hold;
        lock_src_d = lock_src_q;
        if (req_fire) begin
            last_d   = sel;
            locked_d = 1'b0;
        end else if (mem_req_valid) begin
            locked_d   = 1'b1;
            lock_src_d = sel;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_q     <= SRC_LS;
            locked_q   <= 1'b0;
            lock_src_q <= SRC_IF;
        end else begin
            last_q     <= last_d;
            locked_q   <= locked_d;
            lock_src_q <= lock_src_d;
        end
    end

    mem_port_arbiter_src_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .T     (src_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (req_fire),
        .push_data (sel),
        .pop       (resp_fire),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .head      (fifo_head)
    );

    resp_without_req_a: assert property (@(posedge clk) disable iff (rst)
        !(mem_resp_valid && fifo_empty));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scenario bench for mem_port_arbiter: grant order, stall lock, full queue, response routing, reset.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic        clk;
    logic        rst;
    logic        if_req_valid, if_req_ready, if_resp_valid, if_resp_ready;
    logic        ls_req_valid, ls_req_ready, ls_resp_valid, ls_resp_ready;
    logic        mem_req_valid, mem_req_ready, mem_resp_valid, mem_resp_ready;
    mem_req_t    if_req_data, ls_req_data, mem_req_data;
    logic [31:0] if_resp_data, ls_resp_data, mem_resp_data;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;
    src_t        resp_q[$];

    mem_port_arbiter #(.MAX_OUTSTANDING(2)) dut (
        .clk(clk), .rst(rst),
        .if_req_valid(if_req_valid), .if_req_ready(if_req_ready), .if_req_data(if_req_data),
        .if_resp_valid(if_resp_valid), .if_resp_ready(if_resp_ready), .if_resp_data(if_resp_data),
        .ls_req_valid(ls_req_valid), .ls_req_ready(ls_req_ready), .ls_req_data(ls_req_data),
        .ls_resp_valid(ls_resp_valid), .ls_resp_ready(ls_resp_ready), .ls_resp_data(ls_resp_data),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_data(mem_req_data),
        .mem_resp_valid(mem_resp_valid), .mem_resp_ready(mem_resp_ready), .mem_resp_data(mem_resp_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    function automatic mem_req_t mk(input logic [31:0] a);
        mem_req_t r;
        r.a  = a;
        r.we = a[0];
        r.be = 4'hF;
        r.d  = ~a;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1;
        if_req_valid = 1'b0; ls_req_valid = 1'b0; mem_resp_valid = 1'b0;
        mem_req_ready = 1'b1; if_resp_ready = 1'b1; ls_resp_ready = 1'b1;
        if_req_data = mk(32'h0); ls_req_data = mk(32'h0); mem_resp_data = '0;
        resp_q.delete();
        tick();
        tick();
        rst = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks++; if (mem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mem_req_valid: got %b expected 0", mem_req_valid); end
        n_checks++; if (if_resp_valid !== 1'b0 || ls_resp_valid !== 1'b0) begin n_fail++; $display("FAIL rst_resp_valid: got %b%b expected 00", if_resp_valid, ls_resp_valid); end
        n_checks++; if (mem_resp_ready !== 1'b0) begin n_fail++; $display("FAIL rst_mem_resp_ready: got %b expected 0", mem_resp_ready); end
        n_checks++; if (if_req_ready !== 1'b1 || ls_req_ready !== 1'b0) begin n_fail++; $display("FAIL rst_req_ready: got if=%b ls=%b expected if=1 ls=0", if_req_ready, ls_req_ready); end
        n_checks++; if (dut.u_fifo.count_q !== 2'd0) begin n_fail++; $display("FAIL rst_count: got %0d expected 0", dut.u_fifo.count_q); end
    endtask

    task automatic test_if_only();
        mem_req_t exp_req;
        src_t     es;
        apply_reset();
        if_req_valid = 1'b1;
        if_req_data  = mk(32'h100);
        exp_req      = mk(32'h100);
        #1;
        n_checks++; if (mem_req_valid !== 1'b1 || mem_req_data !== exp_req) begin n_fail++; $display("FAIL if_only_req: got v=%b d=%h expected v=1 d=%h", mem_req_valid, mem_req_data, exp_req); end
        if (if_req_ready === 1'b1) resp_q.push_back(SRC_IF);
        tick();
        if_req_valid   = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h0000_0013;
        #1;
        es = (resp_q.size() != 0) ? resp_q.pop_front() : SRC_LS;
        n_checks++; if (es !== SRC_IF || if_resp_valid !== 1'b1 || if_resp_data !== 32'h0000_0013) begin n_fail++; $display("FAIL if_only_resp: got v=%b d=%h expected v=1 d=00000013", if_resp_valid, if_resp_data); end
        n_checks++; if (ls_resp_valid !== 1'b0) begin n_fail++; $display("FAIL if_only_ls_quiet: got %b expected 0", ls_resp_valid); end
        tick();
        mem_resp_valid = 1'b0;
        #1;
        n_checks++; if (dut.u_fifo.count_q !== 2'd0) begin n_fail++; $display("FAIL if_only_drain: got %0d expected 0", dut.u_fifo.count_q); end
    endtask

    task automatic test_round_robin();
        src_t        exp_src, es;
        mem_req_t    exp_req;
        logic [31:0] exp_data;
        apply_reset();
        for (int i = 0; i < 5; i++) begin
            if_req_valid = (i < 4);
            ls_req_valid = (i < 4);
            if_req_data  = mk(32'h200 + i);
            ls_req_data  = mk(32'h300 + i);
            mem_resp_valid = (i > 0);
            exp_data       = 32'hA + i - 1;
            mem_resp_data  = exp_data;
            #1;
            if (i < 4) begin
                exp_src = (i % 2 == 0) ? SRC_IF : SRC_LS;
                exp_req = (exp_src == SRC_IF) ? mk(32'h200 + i) : mk(32'h300 + i);
                n_checks++; if (mem_req_valid !== 1'b1 || mem_req_data !== exp_req) begin n_fail++; $display("FAIL rr_grant%0d: got v=%b d=%h expected v=1 d=%h", i, mem_req_valid, mem_req_data, exp_req); end
                n_checks++; if (if_req_ready !== (exp_src == SRC_IF) || ls_req_ready !== (exp_src == SRC_LS)) begin n_fail++; $display("FAIL rr_ready%0d: got if=%b ls=%b expected src %0d", i, if_req_ready, ls_req_ready, exp_src); end
                resp_q.push_back(exp_src);
            end
            if (i > 0) begin
                es = resp_q.pop_front();
                n_checks++;
                if (if_resp_valid !== (es == SRC_IF) || ls_resp_valid !== (es == SRC_LS) ||
                    ((es == SRC_IF) ? if_resp_data : ls_resp_data) !== exp_data) begin
                    n_fail++; $display("FAIL rr_resp%0d: got if=%b ls=%b d=%h expected src %0d d=%h", i, if_resp_valid, ls_resp_valid, mem_resp_data, es, exp_data);
                end
            end
            tick();
        end
        mem_resp_valid = 1'b0;
    endtask

    task automatic test_stall();
        mem_req_t exp_ls, exp_if;
        src_t     es;
        apply_reset();
        exp_ls = mk(32'h400);
        exp_if = mk(32'h500);
        mem_req_ready = 1'b0;
        ls_req_valid  = 1'b1;
        ls_req_data   = mk(32'h400);
        if_req_data   = mk(32'h500);
        for (int c = 0; c < 3; c++) begin
            if_req_valid = (c >= 1);
            #1;
            n_checks++; if (mem_req_valid !== 1'b1 || mem_req_data !== exp_ls || if_req_ready !== 1'b0) begin n_fail++; $display("FAIL stall_hold%0d: got v=%b d=%h ifr=%b expected v=1 d=%h ifr=0", c, mem_req_valid, mem_req_data, if_req_ready, exp_ls); end
            tick();
        end
        mem_req_ready = 1'b1;
        #1;
        n_checks++; if (mem_req_data !== exp_ls || ls_req_ready !== 1'b1) begin n_fail++; $display("FAIL stall_release: got d=%h lsr=%b expected d=%h lsr=1", mem_req_data, ls_req_ready, exp_ls); end
        resp_q.push_back(SRC_LS);
        tick();
        ls_req_valid = 1'b0;
        #1;
        n_checks++; if (mem_req_valid !== 1'b1 || mem_req_data !== exp_if || if_req_ready !== 1'b1) begin n_fail++; $display("FAIL stall_next_if: got v=%b d=%h ifr=%b expected v=1 d=%h ifr=1", mem_req_valid, mem_req_data, if_req_ready, exp_if); end
        resp_q.push_back(SRC_IF);
        tick();
        if_req_valid   = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h55;
        #1;
        es = resp_q.pop_front();
        n_checks++; if (es !== SRC_LS || ls_resp_valid !== 1'b1 || if_resp_valid !== 1'b0 || ls_resp_data !== 32'h55) begin n_fail++; $display("FAIL stall_resp_ls: got ls=%b if=%b d=%h expected ls=1 if=0 d=00000055", ls_resp_valid, if_resp_valid, ls_resp_data); end
        tick();
        mem_resp_data = 32'h66;
        #1;
        es = resp_q.pop_front();
        n_checks++; if (es !== SRC_IF || if_resp_valid !== 1'b1 || ls_resp_valid !== 1'b0 || if_resp_data !== 32'h66) begin n_fail++; $display("FAIL stall_resp_if: got if=%b ls=%b d=%h expected if=1 ls=0 d=00000066", if_resp_valid, ls_resp_valid, if_resp_data); end
        tick();
        mem_resp_valid = 1'b0;
    endtask

    task automatic test_full();
        mem_req_t exp_req;
        src_t     es;
        apply_reset();
        if_req_valid = 1'b1;
        for (int c = 0; c < 2; c++) begin
            if_req_data = mk(32'h600 + c);
            exp_req     = mk(32'h600 + c);
            #1;
            n_checks++; if (mem_req_valid !== 1'b1 || mem_req_data !== exp_req) begin n_fail++; $display("FAIL full_fill%0d: got v=%b d=%h expected v=1 d=%h", c, mem_req_valid, mem_req_data, exp_req); end
            resp_q.push_back(SRC_IF);
            tick();
        end
        if_req_data    = mk(32'h602);
        exp_req        = mk(32'h602);
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h71;
        #1;
        n_checks++; if (mem_req_valid !== 1'b0 || if_req_ready !== 1'b0 || ls_req_ready !== 1'b0) begin n_fail++; $display("FAIL full_block: got v=%b ifr=%b lsr=%b expected 0 0 0", mem_req_valid, if_req_ready, ls_req_ready); end
        n_checks++; if (dut.u_fifo.count_q !== 2'd2) begin n_fail++; $display("FAIL full_count: got %0d expected 2", dut.u_fifo.count_q); end
        es = resp_q.pop_front();
        n_checks++; if (es !== SRC_IF || if_resp_valid !== 1'b1 || if_resp_data !== 32'h71) begin n_fail++; $display("FAIL full_resp0: got v=%b d=%h expected v=1 d=00000071", if_resp_valid, if_resp_data); end
        tick();
        mem_resp_data = 32'h72;
        #1;
        n_checks++; if (mem_req_valid !== 1'b1 || mem_req_data !== exp_req || dut.u_fifo.count_q !== 2'd1) begin n_fail++; $display("FAIL full_third: got v=%b d=%h cnt=%0d expected v=1 d=%h cnt=1", mem_req_valid, mem_req_data, dut.u_fifo.count_q, exp_req); end
        resp_q.push_back(SRC_IF);
        es = resp_q.pop_front();
        n_checks++; if (es !== SRC_IF || if_resp_valid !== 1'b1 || if_resp_data !== 32'h72) begin n_fail++; $display("FAIL full_resp1: got v=%b d=%h expected v=1 d=00000072", if_resp_valid, if_resp_data); end
        tick();
        if_req_valid  = 1'b0;
        mem_resp_data = 32'h73;
        #1;
        es = resp_q.pop_front();
        n_checks++; if (es !== SRC_IF || if_resp_valid !== 1'b1 || if_resp_data !== 32'h73) begin n_fail++; $display("FAIL full_resp2: got v=%b d=%h expected v=1 d=00000073", if_resp_valid, if_resp_data); end
        tick();
        mem_resp_valid = 1'b0;
        #1;
        n_checks++; if (dut.u_fifo.count_q !== 2'd0) begin n_fail++; $display("FAIL full_drain: got %0d expected 0", dut.u_fifo.count_q); end
    endtask

    task automatic test_resp_backpressure();
        src_t es;
        apply_reset();
        if_req_valid = 1'b1;
        if_req_data  = mk(32'h700);
        #1;
        if (if_req_ready === 1'b1) resp_q.push_back(SRC_IF);
        tick();
        if_req_valid   = 1'b0;
        if_resp_ready  = 1'b0;
        mem_resp_valid = 1'b1;
        mem_resp_data  = 32'h81;
        for (int c = 0; c < 3; c++) begin
            #1;
            n_checks++; if (mem_resp_ready !== 1'b0 || dut.u_fifo.count_q !== 2'd1) begin n_fail++; $display("FAIL bp_hold%0d: got rdy=%b cnt=%0d expected rdy=0 cnt=1", c, mem_resp_ready, dut.u_fifo.count_q); end
            tick();
        end
        if_resp_ready = 1'b1;
        #1;
        es = (resp_q.size() != 0) ? resp_q.pop_front() : SRC_LS;
        n_checks++; if (es !== SRC_IF || mem_resp_ready !== 1'b1 || if_resp_valid !== 1'b1 || if_resp_data !== 32'h81) begin n_fail++; $display("FAIL bp_release: got rdy=%b v=%b d=%h expected rdy=1 v=1 d=00000081", mem_resp_ready, if_resp_valid, if_resp_data); end
        tick();
        mem_resp_valid = 1'b0;
        #1;
        n_checks++; if (dut.u_fifo.count_q !== 2'd0) begin n_fail++; $display("FAIL bp_pop: got %0d expected 0", dut.u_fifo.count_q); end
    endtask

    task automatic test_reset_mid();
        mem_req_t exp_if;
        apply_reset();
        if_req_valid = 1'b1; ls_req_valid = 1'b1;
        if_req_data  = mk(32'h800);
        ls_req_data  = mk(32'h900);
        exp_if       = mk(32'h800);
        tick();
        tick();
        if_req_valid = 1'b0; ls_req_valid = 1'b0;
        #1;
        n_checks++; if (dut.u_fifo.count_q !== 2'd2) begin n_fail++; $display("FAIL mid_pre_count: got %0d expected 2", dut.u_fifo.count_q); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (dut.u_fifo.count_q !== 2'd0) begin n_fail++; $display("FAIL mid_async_count: got %0d expected 0", dut.u_fifo.count_q); end
        tick();
        rst = 1'b0;
        ls_req_valid  = 1'b1;
        mem_req_ready = 1'b0;
        tick();
        n_checks++; if (dut.locked_q !== 1'b1) begin n_fail++; $display("FAIL mid_lock_set: got %b expected 1", dut.locked_q); end
        #2 rst = 1'b1;
        #1;
        n_checks++; if (dut.locked_q !== 1'b0) begin n_fail++; $display("FAIL mid_lock_clr: got %b expected 0", dut.locked_q); end
        tick();
        rst = 1'b0;
        mem_req_ready = 1'b1;
        if_req_valid  = 1'b1;
        #1;
        n_checks++; if (if_req_ready !== 1'b1 || mem_req_data !== exp_if) begin n_fail++; $display("FAIL mid_first_grant: got ifr=%b d=%h expected ifr=1 d=%h", if_req_ready, mem_req_data, exp_if); end
        tick();
        if_req_valid = 1'b0; ls_req_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_if_only();
        test_round_robin();
        test_stall();
        test_full();
        test_resp_backpressure();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
